// File: rtl/thd_pkg.sv
// Shared constants and FSM encoding for the THDi frame-energy stage.
// Widths sized so a full-scale 32-sample frame cannot overflow any accumulator.
package thd_pkg;

   localparam int FRAME_N   = 32;
   localparam int TW_W      = 16;
   localparam int TW_FRAC   = 15;
   localparam int ACC_TOT_W = 36;
   localparam int ACC_DFT_W = 38;
   localparam int SQ_W      = 44;

   typedef enum logic [1:0] {IDLE, MAC, SQ, OUT} state_t;

endpackage

// File: rtl/thd_twiddle_rom32.sv
// Combinational 32-point twiddle ROM: Q1.15 cos/sin of 2*pi*idx/32.
// Built from one quarter-wave table so each full period sums to exactly zero.
module thd_twiddle_rom32 import thd_pkg::*; (
   input  logic        [4:0]      idx,
   output logic signed [TW_W-1:0] cos_q,
   output logic signed [TW_W-1:0] sin_q
);

   function automatic logic signed [TW_W-1:0] quarter(input logic [3:0] i);
      case (i)
         4'd0:    return 16'sd32767;
         4'd1:    return 16'sd32137;
         4'd2:    return 16'sd30273;
         4'd3:    return 16'sd27245;
         4'd4:    return 16'sd23170;
         4'd5:    return 16'sd18204;
         4'd6:    return 16'sd12539;
         4'd7:    return 16'sd6393;
         default: return 16'sd0;
      endcase
   endfunction

   function automatic logic signed [TW_W-1:0] cos_lut(input logic [4:0] n);
      logic [3:0] r;
      logic [3:0] rr;
      r  = {1'b0, n[2:0]};
      rr = 4'd8 - r;
      case (n[4:3])
         2'd0:    return quarter(r);
         2'd1:    return -quarter(rr);
         2'd2:    return -quarter(r);
         default: return quarter(rr);
      endcase
   endfunction

   // sin(n) = cos(n - 8), with the 5-bit add wrapping modulo 32
   assign cos_q = cos_lut(idx);
   assign sin_q = cos_lut(idx + 5'd24);

endmodule

// File: rtl/thd_frame_energy.sv
// Frame energy + DFT bin-1 energy over 32 latched samples, one shared serial MAC.
// Latency 34 clocks capture-to-out_valid; frames arriving while busy are dropped
// (flagged in sticky overrun when THD_OVERRUN_DETECT_EN is defined, else overrun=0).
module thd_frame_energy import thd_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_valid,
   input  logic signed [DATA_W-1:0] d_in0,  d_in1,  d_in2,  d_in3,
   input  logic signed [DATA_W-1:0] d_in4,  d_in5,  d_in6,  d_in7,
   input  logic signed [DATA_W-1:0] d_in8,  d_in9,  d_in10, d_in11,
   input  logic signed [DATA_W-1:0] d_in12, d_in13, d_in14, d_in15,
   input  logic signed [DATA_W-1:0] d_in16, d_in17, d_in18, d_in19,
   input  logic signed [DATA_W-1:0] d_in20, d_in21, d_in22, d_in23,
   input  logic signed [DATA_W-1:0] d_in24, d_in25, d_in26, d_in27,
   input  logic signed [DATA_W-1:0] d_in28, d_in29, d_in30, d_in31,
   output logic                     busy,
   output logic                     out_valid,
   output logic        [OUT_W-1:0]  total_energy,
   output logic        [OUT_W-1:0]  fund_energy,
   output logic                     overrun
);

   localparam int RS_W = ACC_DFT_W - TW_FRAC;

   logic signed [DATA_W-1:0]    d_arr   [FRAME_N];
   logic signed [DATA_W-1:0]    frame_q [FRAME_N];
   state_t                      state, state_nxt;
   logic        [4:0]           idx;
   logic        [ACC_TOT_W-1:0] acc_tot;
   logic signed [ACC_DFT_W-1:0] acc_re, acc_im;
   logic        [SQ_W-1:0]      sq_re, sq_im;
   logic                        capture;

   logic signed [DATA_W-1:0]      x;
   logic signed [TW_W-1:0]        cos_q, sin_q;
   logic signed [2*DATA_W-1:0]    x_sq;
   logic signed [DATA_W+TW_W-1:0] p_re, p_im;
   logic signed [RS_W-1:0]        re_s, im_s;
   logic signed [2*RS_W-1:0]      re_sq, im_sq;
   logic        [SQ_W:0]          sq_sum;

   assign d_arr = '{d_in0,  d_in1,  d_in2,  d_in3,  d_in4,  d_in5,  d_in6,  d_in7,
                    d_in8,  d_in9,  d_in10, d_in11, d_in12, d_in13, d_in14, d_in15,
                    d_in16, d_in17, d_in18, d_in19, d_in20, d_in21, d_in22, d_in23,
                    d_in24, d_in25, d_in26, d_in27, d_in28, d_in29, d_in30, d_in31};

   thd_twiddle_rom32 u_rom (
      .idx   (idx),
      .cos_q (cos_q),
      .sin_q (sin_q)
   );

   assign x      = frame_q[idx];
   assign x_sq   = x * x;
   assign p_re   = x * cos_q;
   assign p_im   = x * sin_q;
   assign re_s   = RS_W'(acc_re >>> TW_FRAC);
   assign im_s   = RS_W'(acc_im >>> TW_FRAC);
   assign re_sq  = re_s * re_s;
   assign im_sq  = im_s * im_s;
   assign sq_sum = {1'b0, sq_re} + {1'b0, sq_im};

   // Only IDLE accepts a frame; SQ/OUT count as busy as well
   assign capture = (state == IDLE) && frame_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_valid) state_nxt = MAC;
         MAC:     if (idx == 5'd31) state_nxt = SQ;
         SQ:      state_nxt = OUT;
         default: state_nxt = IDLE;
      endcase
   end

   // Sample storage carries no reset; it is always rewritten before use
   always_ff @(posedge clk) begin
      if (capture) frame_q <= d_arr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         acc_tot      <= '0;
         acc_re       <= '0;
         acc_im       <= '0;
         sq_re        <= '0;
         sq_im        <= '0;
         busy         <= 1'b0;
         out_valid    <= 1'b0;
         total_energy <= '0;
         fund_energy  <= '0;
      end else begin
         state     <= state_nxt;
         out_valid <= 1'b0;
         case (state)
            IDLE: if (capture) begin
               idx     <= '0;
               acc_tot <= '0;
               acc_re  <= '0;
               acc_im  <= '0;
               busy    <= 1'b1;
            end
            MAC: begin
               idx     <= idx + 5'd1;
               acc_tot <= acc_tot + ACC_TOT_W'($unsigned(x_sq));
               acc_re  <= acc_re + ACC_DFT_W'(p_re);
               acc_im  <= acc_im - ACC_DFT_W'(p_im);
            end
            SQ: begin
               sq_re <= SQ_W'($unsigned(re_sq));
               sq_im <= SQ_W'($unsigned(im_sq));
            end
            default: begin
               total_energy <= OUT_W'(acc_tot);
               fund_energy  <= OUT_W'(sq_sum >> 4);
               out_valid    <= 1'b1;
               busy         <= 1'b0;
            end
         endcase
      end
   end

`ifdef THD_OVERRUN_DETECT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (frame_valid && (state != IDLE))
         overrun <= 1'b1;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_thd_frame_energy.sv
// Directed bench for thd_frame_energy: latency, energy values, busy drops, reset abort.
module tb_thd_frame_energy;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               frame_valid;
   logic signed [15:0] d [32];
   logic               busy, out_valid, overrun;
   logic [39:0]        total_energy, fund_energy;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int seen;
   int sq_tab [9] = '{0, 3196, 6270, 9102, 11585, 13623, 15137, 16069, 16384};
   longint unsigned diff;
   bit exp_ovr;

   always #5 clk = ~clk;

   thd_frame_energy dut (
      .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
      .d_in0(d[0]),   .d_in1(d[1]),   .d_in2(d[2]),   .d_in3(d[3]),
      .d_in4(d[4]),   .d_in5(d[5]),   .d_in6(d[6]),   .d_in7(d[7]),
      .d_in8(d[8]),   .d_in9(d[9]),   .d_in10(d[10]), .d_in11(d[11]),
      .d_in12(d[12]), .d_in13(d[13]), .d_in14(d[14]), .d_in15(d[15]),
      .d_in16(d[16]), .d_in17(d[17]), .d_in18(d[18]), .d_in19(d[19]),
      .d_in20(d[20]), .d_in21(d[21]), .d_in22(d[22]), .d_in23(d[23]),
      .d_in24(d[24]), .d_in25(d[25]), .d_in26(d[26]), .d_in27(d[27]),
      .d_in28(d[28]), .d_in29(d[29]), .d_in30(d[30]), .d_in31(d[31]),
      .busy(busy), .out_valid(out_valid), .total_energy(total_energy),
      .fund_energy(fund_energy), .overrun(overrun)
   );

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill_dc(input int v);
      for (int i = 0; i < 32; i++) d[i] = 16'(v);
   endtask

   // Caller sits just after a rising edge; the next edge captures. pa/pb are the
   // edge numbers (after capture) at which a stray frame_valid is presented.
   task automatic run_frame(input int pa, input int pb, output int lt);
      lt = -1;
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         frame_valid = (c == pa) || (c == pb);
         if (c == 1 && pa > 0) fill_dc(2000);
         @(posedge clk); #1;
         if (c == 1) check("busy_in_mac", busy, 1);
         if (out_valid) begin
            lt = c;
            break;
         end
      end
      frame_valid = 1'b0;
      if (lt < 0) check("out_valid_timeout", 0, 1);
   endtask

   initial begin
`ifdef THD_OVERRUN_DETECT_EN
      exp_ovr = 1'b1;
`else
      exp_ovr = 1'b0;
`endif
      rst_n = 1'b0;
      frame_valid = 1'b0;
      fill_dc(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_total", total_energy, 0);
      check("rst_fund", fund_energy, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // all-zero frame
      run_frame(-1, -1, lat);
      check("zero_latency", lat, 34);
      check("zero_busy_done", busy, 0);
      check("zero_total", total_energy, 0);
      check("zero_fund", fund_energy, 0);
      @(posedge clk); #1;
      check("out_valid_one_cycle", out_valid, 0);

      // DC 1000
      fill_dc(1000);
      run_frame(-1, -1, lat);
      check("dc_latency", lat, 34);
      check("dc_total", total_energy, 64'd32000000);
      check("dc_fund", fund_energy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("dc_total_held", total_energy, 64'd32000000);

      // alternating +/-1000 (bin 16)
      for (int i = 0; i < 32; i++) d[i] = (i % 2 == 0) ? 16'sd1000 : -16'sd1000;
      run_frame(-1, -1, lat);
      check("alt_latency", lat, 34);
      check("alt_total", total_energy, 64'd32000000);
      check("alt_fund", fund_energy, 0);

      // bin-1 sine, amplitude 16384
      for (int i = 0; i < 32; i++) begin
         int q, v;
         q = i % 16;
         v = (q <= 8) ? sq_tab[q] : sq_tab[16 - q];
         d[i] = (i < 16) ? 16'(v) : 16'(-v);
      end
      run_frame(-1, -1, lat);
      check("sine_latency", lat, 34);
      check("sine_total", total_energy, 64'd4294925328);
      diff = (fund_energy > total_energy) ? 64'(fund_energy - total_energy)
                                          : 64'(total_energy - fund_energy);
      if (diff * 200 > 64'(total_energy)) $display("sine fund_energy=%0d", fund_energy);
      check("sine_fund_within_0p5pct", (diff * 200 <= 64'(total_energy)), 1);

      // stray frames at MAC idx=10 and in OUT are dropped
      fill_dc(500);
      run_frame(11, 34, lat);
      check("busy_drop_latency", lat, 34);
      check("busy_drop_total", total_energy, 64'd8000000);
      check("busy_drop_fund", fund_energy, 0);
      check("overrun_set", overrun, exp_ovr);
      fill_dc(1000);
      run_frame(-1, -1, lat);
      check("overrun_sticky", overrun, exp_ovr);
      check("after_drop_total", total_energy, 64'd32000000);

      // reset at MAC idx=20 aborts the frame
      fill_dc(700);
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_total", total_energy, 0);
      check("abort_fund", fund_energy, 0);
      check("abort_overrun", overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("abort_no_out_valid", seen, 0);
      fill_dc(1000);
      run_frame(-1, -1, lat);
      check("post_abort_latency", lat, 34);
      check("post_abort_total", total_energy, 64'd32000000);
      check("post_abort_fund", fund_energy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
